// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller.
// Arbitrates next-PC redirects coming from exceptions, branch mispredicts
// and the branch predictor. Exceptions and mispredicts ("hard events") are
// captured into a pending register. The front end is then flushed for
// FLUSH_CYCLES cycles, and the captured target is offered until fetch
// accepts it. Each hard event also bumps the fetch epoch, which lets
// downstream logic discard wrong-path work.
module pc_redirect_ctrl #(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int EPOCH_W      = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               except_valid_i,
    input  logic [XLEN-1:0]    except_pc_i,
    input  logic               res_valid_i,
    input  logic               res_mispredict_i,
    input  logic [XLEN-1:0]    res_target_i,
    input  logic               pred_taken_i,
    input  logic [XLEN-1:0]    pred_target_i,
    input  logic               fetch_ready_i,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic [1:0]         redirect_src_o,
    output logic               flush_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_PRED = 2'b01;
    localparam logic [1:0] SRC_MISP = 2'b10;
    localparam logic [1:0] SRC_EXC  = 2'b11;

    // The counter is 4 bits wide, so FLUSH_CYCLES must stay within 1..15.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
    logic [1:0]         pend_src_q, pend_src_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;

    logic hard_event;
    logic pend_live;

    // Classify this cycle's inputs. The pending register is "live" while its
    // target has not yet been handed to fetch. This covers the whole of FLUSH,
    // and PEND until the handshake.
    always_comb begin
        hard_event = except_valid_i | (res_valid_i & res_mispredict_i);
        pend_live  = (state_q == ST_FLUSH) |
                     ((state_q == ST_PEND) & ~fetch_ready_i);
    end

    // Next-state logic. A hard event always restarts the flush. A mispredict
    // must not clobber an exception that has not been delivered yet.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_pc_d  = pend_pc_q;
        pend_src_d = pend_src_q;
        epoch_d    = epoch_q;

        if (hard_event) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
            epoch_d = epoch_q + EPOCH_W'(1);
            if (except_valid_i) begin
                pend_pc_d  = except_pc_i;
                pend_src_d = SRC_EXC;
            end else if (!(pend_live && (pend_src_q == SRC_EXC))) begin
                pend_pc_d  = res_target_i;
                pend_src_d = SRC_MISP;
            end
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_PEND;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_PEND: begin
                    if (fetch_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset that discards any flush or
    // pending redirect in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            pend_pc_q  <= '0;
            pend_src_q <= SRC_NONE;
            epoch_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_pc_q  <= pend_pc_d;
            pend_src_q <= pend_src_d;
            epoch_q    <= epoch_d;
        end
    end

    // Output decode. During reset the block behaves as if idle with only a
    // prediction pass-through. Redirect pc/src are zero whenever valid is low.
    always_comb begin
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        redirect_src_o   = SRC_NONE;
        flush_o          = 1'b0;
        busy_o           = 1'b0;
        epoch_o          = epoch_q;

        if (rst_i) begin
            if (pred_taken_i) begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = pred_target_i;
                redirect_src_o   = SRC_PRED;
            end
        end else begin
            busy_o = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (!hard_event && pred_taken_i) begin
                        redirect_valid_o = 1'b1;
                        redirect_pc_o    = pred_target_i;
                        redirect_src_o   = SRC_PRED;
                    end
                end
                ST_FLUSH: begin
                    flush_o = 1'b1;
                end
                ST_PEND: begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = pend_pc_q;
                    redirect_src_o   = pend_src_q;
                end
                default: begin
                    redirect_valid_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Testbench for pc_redirect_ctrl.
// The stimulus is a cycle-by-cycle vector table with hand-computed expected
// outputs, followed by a bounded event-to-redirect latency sequence.
module tb_pc_redirect_ctrl;

    localparam int XLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            except_valid_i;
    logic [XLEN-1:0] except_pc_i;
    logic            res_valid_i;
    logic            res_mispredict_i;
    logic [XLEN-1:0] res_target_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] pred_target_i;
    logic            fetch_ready_i;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [1:0]      redirect_src_o;
    logic            flush_o;
    logic [2:0]      epoch_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        exc;
        logic [63:0] exc_pc;
        logic        mis;
        logic [63:0] mis_pc;
        logic        pred;
        logic [63:0] pred_pc;
        logic        fr;
        logic        e_rv;
        logic [63:0] e_pc;
        logic [1:0]  e_src;
        logic        e_flush;
        logic [2:0]  e_epoch;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    pc_redirect_ctrl #(
        .XLEN(XLEN),
        .FLUSH_CYCLES(2),
        .EPOCH_W(3)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .except_valid_i(except_valid_i),
        .except_pc_i(except_pc_i),
        .res_valid_i(res_valid_i),
        .res_mispredict_i(res_mispredict_i),
        .res_target_i(res_target_i),
        .pred_taken_i(pred_taken_i),
        .pred_target_i(pred_target_i),
        .fetch_ready_i(fetch_ready_i),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o),
        .redirect_src_o(redirect_src_o),
        .flush_o(flush_o),
        .epoch_o(epoch_o),
        .busy_o(busy_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic rst, input logic exc, input logic [63:0] exc_pc,
                                input logic mis, input logic [63:0] mis_pc,
                                input logic pred, input logic [63:0] pred_pc, input logic fr,
                                input logic e_rv, input logic [63:0] e_pc, input logic [1:0] e_src,
                                input logic e_flush, input logic [2:0] e_epoch, input logic e_busy);
        vec_t v;
        v.rst = rst;   v.exc = exc;   v.exc_pc = exc_pc; v.mis = mis; v.mis_pc = mis_pc;
        v.pred = pred; v.pred_pc = pred_pc; v.fr = fr;
        v.e_rv = e_rv; v.e_pc = e_pc; v.e_src = e_src; v.e_flush = e_flush;
        v.e_epoch = e_epoch; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst_i            = v.rst;
        except_valid_i   = v.exc;
        except_pc_i      = v.exc_pc;
        res_valid_i      = v.mis;
        res_mispredict_i = v.mis;
        res_target_i     = v.mis_pc;
        pred_taken_i     = v.pred;
        pred_target_i    = v.pred_pc;
        fetch_ready_i    = v.fr;
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, actual, expected);
        end
    endtask

    task automatic checkRow(input int row, input vec_t v);
        checkOutput("redirect_valid", row, 64'(redirect_valid_o), 64'(v.e_rv));
        checkOutput("redirect_pc",    row, redirect_pc_o,         v.e_pc);
        checkOutput("redirect_src",   row, 64'(redirect_src_o),   64'(v.e_src));
        checkOutput("flush",          row, 64'(flush_o),          64'(v.e_flush));
        checkOutput("epoch",          row, 64'(epoch_o),          64'(v.e_epoch));
        checkOutput("busy",           row, 64'(busy_o),           64'(v.e_busy));
    endtask

    initial begin
        int lat;
        vec_t idle_v;

        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(idle_v);
        rst_i = 1'b1;

        //            rst exc epc      mis mpc      prd ppc      fr   rv pc       src fl ep bsy
        // Reset, then prediction pass-through.
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0,       0,   0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,       0, 0,       1, 'h40,    0,   1, 'h40,    1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 'h1000,  0,   1, 'h1000,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       0,   0, 0,       0, 0, 0, 0));
        // Mispredict at t: the prediction is suppressed, flush for 2 cycles,
        // then the redirect, then idle.
        vecs.push_back(mk(0, 0, 0,       1, 'h2004,  1, 'h5555,  1,   0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 'h5555,  1,   0, 0,       0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   0, 0,       0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   1, 'h2004,  2, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   0, 0,       0, 0, 1, 0));
        // Exception and mispredict together: a single capture, exception wins.
        vecs.push_back(mk(0, 1, 'h8000,  1, 'h2004,  0, 0,       0,   0, 0,       0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       0,   0, 0,       0, 1, 2, 1));
        // A mispredict during FLUSH restarts the counter but keeps the exception.
        vecs.push_back(mk(0, 0, 0,       1, 'h3000,  0, 0,       0,   0, 0,       0, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       0,   0, 0,       0, 1, 3, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       0,   0, 0,       0, 1, 3, 1));
        // PEND held for 5 cycles without fetch_ready; the prediction is ignored.
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0,   0, 0,       1, 'h9999,  0,   1, 'h8000,  3, 0, 3, 1));
        // Handshake and mispredict in the same cycle: back to FLUSH with the new target.
        vecs.push_back(mk(0, 0, 0,       1, 'h4444,  0, 0,       1,   1, 'h8000,  3, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   0, 0,       0, 1, 4, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   0, 0,       0, 1, 4, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   1, 'h4444,  2, 0, 4, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   0, 0,       0, 0, 4, 0));
        // Back-to-back events: the epoch wraps 7 -> 0.
        vecs.push_back(mk(0, 0, 0,       1, 'h10,    0, 0,       0,   0, 0,       0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h20,    0, 0,       0,   0, 0,       0, 1, 5, 1));
        vecs.push_back(mk(0, 0, 0,       1, 'h30,    0, 0,       0,   0, 0,       0, 1, 6, 1));
        vecs.push_back(mk(0, 0, 0,       1, 'h40,    0, 0,       0,   0, 0,       0, 1, 7, 1));
        vecs.push_back(mk(0, 0, 0,       1, 'h50,    0, 0,       0,   0, 0,       0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       0,   0, 0,       0, 1, 1, 1));
        // Reset mid-FLUSH discards everything.
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0,       0,   0, 0,       0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,       1,   0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 'h77,    1,   1, 'h77,    1, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk_i);
            applyStimulus(vecs[i]);
            #1;
            checkRow(i, vecs[i]);
        end

        // Event-to-redirect latency, measured with a bounded wait.
        @(negedge clk_i);
        applyStimulus(mk(0, 0, 0, 1, 'hABC, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("lat_event_cycle_valid", 0, 64'(redirect_valid_o), 64'd0);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            #1;
            if (redirect_valid_o) begin
                lat = c;
                break;
            end
        end
        checkOutput("latency", 0, 64'(lat), 64'd3);
        checkOutput("lat_pc", 0, redirect_pc_o, 64'hABC);
        checkOutput("lat_src", 0, 64'(redirect_src_o), 64'd2);
        @(negedge clk_i);
        #1;
        checkOutput("lat_busy_after", 0, 64'(busy_o), 64'd0);
        checkOutput("lat_epoch_after", 0, 64'(epoch_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
